// File: rtl/seq_divider_if.sv
//------------------------------------------------------------------------------
// Module      : seq_divider_if
// Description : Request/result bundle for the sequential divider.
//               master : drives start/dividend/divisor, observes results
//               slave  : the divider itself
//   start     requester -> divider  request, sampled only while idle
//   dividend  requester -> divider  DW-bit unsigned dividend
//   divisor   requester -> divider  VW-bit unsigned divisor
//   busy      divider -> requester  iteration in progress
//   done      divider -> requester  one-cycle completion pulse
//   q / r     divider -> requester  quotient / remainder
//   dz        divider -> requester  last operation divided by zero
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, q, r, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, q, r, dz
    );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// Module      : seq_divider
// Description : Multi-cycle unsigned restoring divider, one quotient bit per
//               clock. Companion of the 4x4 multiplier datapath: DW-bit
//               dividend, VW-bit divisor, start/busy/done handshake.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of seq_divider_if (start, dividend, divisor,
//          busy, done, q, r, dz)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    seq_divider_if.slave bus
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [VW-1:0] r_rem;      // stored partial remainder, always < divisor
    logic [DW-1:0] r_dvd;      // dividend shifts out MSB-first, quotient shifts in
    logic [VW-1:0] r_dvs;
    logic [DW-1:0] r_q;
    logic [VW-1:0] r_r;
    logic          r_dz;

    logic          w_busy;
    logic          w_done;
    logic          w_last;
    logic [VW:0]   w_shift;
    logic [VW:0]   w_diff;
    logic          w_ge;
    logic [VW-1:0] w_rem_nxt;

    // Shifted partial remainder needs VW+1 bits. Since it is below 2*divisor,
    // the VW+1-bit trial difference lies in (-2^VW, 2^VW), so its top bit is
    // an exact sign bit and the subtract can never overflow.
    assign w_shift   = {r_rem, r_dvd[DW-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_ge      = ~w_diff[VW];
    assign w_rem_nxt = w_ge ? w_diff[VW-1:0] : w_shift[VW-1:0];
    // Leaving CALC on the count of one stops after exactly DW iterations.
    assign w_last    = (r_cnt == CW'(1));

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next state and handshake outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath: working registers are separate from the result registers so
    // q/r/dz hold the previous result until the new one is complete.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_dvd <= '0;
            r_dvs <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dvd <= bus.dividend;
                        r_dvs <= bus.divisor;
                        r_rem <= '0;
                        r_cnt <= CW'(DW);
                        if (bus.divisor == '0) begin
                            r_q  <= '1;
                            r_r  <= '0;
                            r_dz <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[DW-2:0], w_ge};
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_q  <= {r_dvd[DW-2:0], w_ge};
                        r_r  <= w_rem_nxt;
                        r_dz <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.dz   = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//------------------------------------------------------------------------------
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider. Expected results are
//               queued when an operation is issued and compared whenever the
//               divider pulses done.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_divider_if #(.DW(DW), .VW(VW)) bus ();

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.a = DW'(a);
        e.b = VW'(b);
        if (b == 0) begin
            e.q  = '1;
            e.r  = '0;
            e.dz = 1'b1;
        end else begin
            e.q  = DW'(a / b);
            e.r  = VW'(a % b);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            check_val("result_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                m_e = sb.pop_front();
                check_val($sformatf("q %0d/%0d", m_e.a, m_e.b), bus.q, m_e.q);
                check_val($sformatf("r %0d/%0d", m_e.a, m_e.b), bus.r, m_e.r);
                check_val($sformatf("dz %0d/%0d", m_e.a, m_e.b), bus.dz, m_e.dz);
            end
        end
    end

    // Issue one op; returns at the falling edge after the accepting edge.
    task automatic start_op(input int a, input int b, input bit push);
        @(negedge clk);
        bus.dividend = DW'(a);
        bus.divisor  = VW'(b);
        bus.start    = 1'b1;
        if (push) sb.push_back(model(a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!bus.done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check_val("done_within_bound", (k < bound), 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_q", bus.q, 0);
        check_val("rst_r", bus.r, 0);
        check_val("rst_dz", bus.dz, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_busy", bus.busy, 0);

        // 1: 200/7 with exact busy/done timing
        @(negedge clk);
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        bus.start    = 1'b1;
        sb.push_back(model(200, 7));
        for (int i = 0; i < DW; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            check_val($sformatf("t1_busy_c%0d", i), bus.busy, 1);
            check_val($sformatf("t1_nodone_c%0d", i), bus.done, 0);
            if (i == 3) check_val("t1_q_held", bus.q, 0);
        end
        @(negedge clk);
        check_val("t1_done", bus.done, 1);
        check_val("t1_busy_off", bus.busy, 0);

        // 2: boundary operands
        start_op(255, 1, 1);  wait_done(20);
        start_op(5, 15, 1);   wait_done(20);
        start_op(0, 9, 1);    wait_done(20);

        // 3: divide by zero, then dz clears on a normal op
        start_op(100, 0, 1);
        check_val("t3_dz_latency", bus.done, 1);
        @(negedge clk);
        check_val("t3_done_pulse", bus.done, 0);
        start_op(9, 3, 1);    wait_done(20);

        // 4: operand change and re-start during CALC are ignored
        start_op(200, 7, 1);
        @(negedge clk);
        @(negedge clk);
        bus.dividend = 8'd17;
        bus.divisor  = 4'd2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(20);
        repeat (15) @(negedge clk);
        check_val("t4_sb_drained", sb.size(), 0);

        // 5: asynchronous reset mid-operation
        start_op(200, 7, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check_val("t5_busy", bus.busy, 0);
        check_val("t5_done", bus.done, 0);
        check_val("t5_q", bus.q, 0);
        check_val("t5_r", bus.r, 0);
        check_val("t5_dz", bus.dz, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("t5_idle_busy", bus.busy, 0);
        start_op(45, 6, 1);   wait_done(20);

        // 6: exhaustive sweep with start held high
        @(negedge clk);
        bus.start = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                bus.dividend = DW'(a);
                bus.divisor  = VW'(b);
                sb.push_back(model(a, b));
                @(negedge clk);
                wait_done(20);
            end
        end
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check_val("t6_sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
